// File: rtl/logic_part.sv
// Registered bitwise logic slice of the ALU (AND/OR/XOR/NOR) with valid strobe and opcode error.
// Optional zero/negative status flags are built when LOGIC_PART_FLAGS_EN is defined.
module logic_part #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUop,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             op_err
`ifdef LOGIC_PART_FLAGS_EN
  ,
  output logic             zero,
  output logic             negative
`endif
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_NOR = 4'b0111
  } logic_op_t;

  logic [WIDTH-1:0] next_result;
  logic             next_err;

  always_comb begin
    next_result = '0;
    next_err    = 1'b0;
    case (ALUop)
      OP_AND:  next_result = a & b;
      OP_OR:   next_result = a | b;
      OP_XOR:  next_result = a ^ b;
      OP_NOR:  next_result = ~(a | b);
      default: next_err    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= next_result;
        op_err <= next_err;
      end
    end
  end

`ifdef LOGIC_PART_FLAGS_EN
  // Flags are derived from next_result so they track the register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b1;
      negative <= 1'b0;
    end else if (in_valid) begin
      zero     <= (next_result == '0);
      negative <= next_result[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_logic_part.sv
// Directed and random self-checking bench for logic_part (WIDTH = 32).
// Flag checks compile in when LOGIC_PART_FLAGS_EN is defined.
module tb_logic_part;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUop;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             op_err;
`ifdef LOGIC_PART_FLAGS_EN
  logic             zero;
  logic             negative;
`endif

  int unsigned num_checks = 0;
  int unsigned num_errors = 0;

  logic_part #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ALUop     (ALUop),
    .result    (result),
    .out_valid (out_valid),
    .op_err    (op_err)
`ifdef LOGIC_PART_FLAGS_EN
    ,
    .zero      (zero),
    .negative  (negative)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_zero, input logic exp_neg);
`ifdef LOGIC_PART_FLAGS_EN
    check({tag, ".zero"}, WIDTH'(zero), WIDTH'(exp_zero));
    check({tag, ".negative"}, WIDTH'(negative), WIDTH'(exp_neg));
`else
    if (exp_zero === 1'bx || exp_neg === 1'bx) $display("%s: flags not built", tag);
`endif
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic [3:0] op);
    in_valid = v;
    a        = aa;
    b        = bb;
    ALUop    = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".result"}, result, '0);
    check({tag, ".out_valid"}, WIDTH'(out_valid), '0);
    check({tag, ".op_err"}, WIDTH'(op_err), '0);
    check_flags(tag, 1'b1, 1'b0);
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (op)
      4'b0100: return x & y;
      4'b0101: return x | y;
      4'b0110: return x ^ y;
      4'b0111: return ~(x | y);
      default: return '0;
    endcase
  endfunction

  logic [WIDTH-1:0] exp_r;
  logic             exp_v;
  logic             exp_e;
  logic             rv;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [3:0]       rop;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    ALUop    = 4'b0000;
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 32'h0, 32'h7FF, 4'b0100);
    check("and.result", result, 32'h0000_0000);
    check("and.out_valid", WIDTH'(out_valid), 1);
    check("and.op_err", WIDTH'(op_err), 0);
    check_flags("and", 1'b1, 1'b0);

    drive(1'b1, 32'h1F, 32'h7FF, 4'b0101);
    check("or.result", result, 32'h0000_07FF);
    check_flags("or", 1'b0, 1'b0);
    drive(1'b1, 32'h1F, 32'h7FF, 4'b0110);
    check("xor.result", result, 32'h0000_07E0);
    check("xor.out_valid", WIDTH'(out_valid), 1);

    drive(1'b1, 32'h1F, 32'h7FF, 4'b0111);
    check("nor.result", result, 32'hFFFF_F800);
    check_flags("nor", 1'b0, 1'b1);

    drive(1'b1, 32'h1F, 32'h7FF, 4'b0000);
    check("unsup.result", result, 32'h0);
    check("unsup.op_err", WIDTH'(op_err), 1);
    check("unsup.out_valid", WIDTH'(out_valid), 1);
    drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0101);
    check("unsup_hold.result", result, 32'h0);
    check("unsup_hold.op_err", WIDTH'(op_err), 1);
    check("unsup_hold.out_valid", WIDTH'(out_valid), 0);

    // A nonzero value must survive idle cycles, and a supported op clears op_err.
    drive(1'b1, 32'h1F, 32'h7FF, 4'b0111);
    check("nor2.op_err", WIDTH'(op_err), 0);
    drive(1'b0, 32'h0, 32'h0, 4'b0100);
    drive(1'b0, 32'h0, 32'h0, 4'b0100);
    check("hold.result", result, 32'hFFFF_F800);
    check("hold.out_valid", WIDTH'(out_valid), 0);
    check_flags("hold", 1'b0, 1'b1);

    drive(1'b1, 32'h1F, 32'h7FF, 4'b0111);
    #2 rst_n = 1'b0;
    #1 check_cleared("async_rst_result");
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 32'h1F, 32'h7FF, 4'b1111);
    check("unsup2.op_err", WIDTH'(op_err), 1);
    #2 rst_n = 1'b0;
    #1 check_cleared("async_rst_err");

    drive(1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 4'b0101);
    check_cleared("reset_wins");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 4'b0110);
    check("post_rst.result", result, 32'hFFFF_FFFF);
    check("post_rst.out_valid", WIDTH'(out_valid), 1);
    check_flags("post_rst", 1'b0, 1'b1);

    exp_r = 32'hFFFF_FFFF;
    exp_e = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rv  = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      rop = 4'(4 + $urandom_range(0, 3));
      drive(rv, ra, rb, rop);
      exp_v = rv;
      if (rv) begin
        exp_r = ref_op(rop, ra, rb);
        exp_e = 1'b0;
      end
      check("rand.result", result, exp_r);
      check("rand.out_valid", WIDTH'(out_valid), WIDTH'(exp_v));
      check("rand.op_err", WIDTH'(op_err), WIDTH'(exp_e));
      check_flags("rand", exp_r == '0, exp_r[WIDTH-1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/logic_part.md
# logic_part

Bitwise logic slice of the single-cycle processor ALU. It takes two operands and a 4-bit ALU opcode, then performs AND, OR, XOR or NOR. The result is registered on the clock edge and accompanied by a valid strobe and an unsupported-opcode error flag. It sits beside the arithmetic and shift slices, and the ALU output mux selects it when `ALUop[3:2] == 2'b01`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits; must be at least 2.

Ports:
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: operands and opcode are valid this cycle.
- `a` input, WIDTH bits: operand A.
- `b` input, WIDTH bits: operand B.
- `ALUop` input, 4 bits: operation select.
- `result` output, WIDTH bits: registered logic result.
- `out_valid` output, 1 bit: `result` was updated on the last edge.
- `op_err` output, 1 bit: the last accepted opcode was unsupported.
- `zero` output, 1 bit: the registered result is all zeros. Present only with `LOGIC_PART_FLAGS_EN`.
- `negative` output, 1 bit: copy of `result[WIDTH-1]`. Present only with `LOGIC_PART_FLAGS_EN`.

## Operation
Opcode decode, applied bitwise over all WIDTH bits:
- `4'b0100` gives `a & b`.
- `4'b0101` gives `a | b`.
- `4'b0110` gives `a ^ b`.
- `4'b0111` gives `~(a | b)`.

Any other opcode is unsupported:
- The computed value is 0.
- `op_err` is set to 1 for that accepted transaction.

Transaction rules:
- On a rising edge with `in_valid = 1`: `result`, `op_err` and the flags load the new values, and `out_valid` is set to 1.
- On a rising edge with `in_valid = 0`: `result`, `op_err` and the flags hold their values, and `out_valid` is cleared to 0.
- There is no back-pressure. Every cycle with `in_valid = 1` is accepted.
- No carry or overflow is produced.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one operation per cycle.
- Outputs are driven only from registers; there is no combinational path from input to output.
- Reset is asynchronous: when `rst_n` falls, outputs clear immediately.
  - `result = 0`, `out_valid = 0`, `op_err = 0`.
  - With the flags feature, `zero = 1` and `negative = 0`.
- Reset arriving mid-stream discards any in-flight result.
- After `rst_n` rises, the first edge with `in_valid = 1` produces a normal result.
- If `rst_n` is low at an edge, reset wins over `in_valid`.

## Configuration
`LOGIC_PART_FLAGS_EN`:
- Defined: the `zero` and `negative` ports and registers exist and update together with `result`.
- Undefined: those ports and registers are omitted. All other behaviour is identical.

## Test plan
- Reset: drive `rst_n` low mid-cycle -> `result = 0`, `out_valid = 0`, `op_err = 0` immediately, with no clock edge needed.
- AND: `a = 0`, `b = 0x7FF`, `ALUop = 0100`, `in_valid = 1` -> next cycle `result = 0x00000000`, `out_valid = 1`, `zero = 1`.
- OR, then XOR, with `b = 0x7FF` and `a = 0x1F` held (back-to-back valid):
  - `ALUop = 0101` -> `0x000007FF`.
  - `ALUop = 0110` -> `0x000007E0`.
- NOR: `a = 0x1F`, `b = 0x7FF`, `ALUop = 0111` -> `result = 0xFFFFF800`, `negative = 1`.
- Unsupported opcode: `ALUop = 0000` with `in_valid = 1` -> `result = 0`, `op_err = 1`. Then drop `in_valid` -> values hold and `out_valid = 0`.
- Random: 1000 random `a`, `b` and supported opcodes with random `in_valid` -> `result` matches the reference model one cycle later.
